// File: rtl/pipe_encode_loader.sv
`default_nettype none
// ============================================================================
// Module   : pipe_encode_loader
// Purpose  : Encodes field-level instruction descriptors into 32-bit MIPS
//            words and writes them sequentially into instruction memory.
// Options  : ENC_BRANCH_DELAY_NOP_EN - append a NOP after every BEQ and J.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_encode_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_load = 2'd1;
`ifdef ENC_BRANCH_DELAY_NOP_EN
   localparam logic [1:0] c_pad  = 2'd2;
`endif
   localparam logic [1:0] c_done = 2'd3;

   localparam logic [2:0] c_k_lw    = 3'd0;
   localparam logic [2:0] c_k_sw    = 3'd1;
   localparam logic [2:0] c_k_rtype = 3'd2;
   localparam logic [2:0] c_k_beq   = 3'd3;
   localparam logic [2:0] c_k_addi  = 3'd4;
   localparam logic [2:0] c_k_j     = 3'd5;
   localparam logic [2:0] c_k_end   = 3'd6;
   localparam logic [2:0] c_k_rsvd  = 3'd7;

   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;

   localparam logic [ADDR_W:0]   c_full     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] c_ptr_last = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] c_ptr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_err;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;

   logic              w_ready;
   logic              w_accept;
   logic              w_full;
   logic [31:0]       w_enc;
   logic              w_write;
   logic              w_err_set;
   logic [31:0]       w_wr_word;

   assign w_ready  = (r_state == c_load) && !start;
   assign w_accept = in_valid && w_ready;
   assign w_full   = (r_count == c_full);

`ifdef ENC_BRANCH_DELAY_NOP_EN
   logic w_is_branch;
   assign w_is_branch = (in_kind == c_k_beq) || (in_kind == c_k_j);
`endif

   always_comb begin
      case (in_kind)
         c_k_lw:    w_enc = {c_op_lw,   in_rs, in_rt, in_imm};
         c_k_sw:    w_enc = {c_op_sw,   in_rs, in_rt, in_imm};
         c_k_rtype: w_enc = {c_op_rtype, in_rs, in_rt, in_rd, in_shamt, in_funct};
         c_k_beq:   w_enc = {c_op_beq,  in_rs, in_rt, in_imm};
         c_k_addi:  w_enc = {c_op_addi, in_rs, in_rt, in_imm};
         c_k_j:     w_enc = {c_op_j,    in_target};
         default:   w_enc = 32'h0000_0000;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; start restarts the load from any non-idle state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_idle: begin
            if (start) w_next_state = c_load;
         end
         c_load: begin
            if (start) begin
               w_next_state = c_load;
            end else if (w_accept) begin
               if (in_kind == c_k_end || w_full) begin
                  w_next_state = c_done;
`ifdef ENC_BRANCH_DELAY_NOP_EN
               end else if (w_is_branch) begin
                  w_next_state = c_pad;
`endif
               end
            end
         end
`ifdef ENC_BRANCH_DELAY_NOP_EN
         c_pad: begin
            w_next_state = (!start && w_full) ? c_done : c_load;
         end
`endif
         c_done: begin
            w_next_state = start ? c_load : c_idle;
         end
         default: begin
            w_next_state = c_idle;
         end
      endcase
   end

   // Outputs and write decision for the coming edge
   always_comb begin
      in_ready  = w_ready;
      busy      = (r_state != c_idle);
      done      = (r_state == c_done);
      w_write   = 1'b0;
      w_err_set = 1'b0;
      w_wr_word = w_enc;
      if (w_accept && in_kind != c_k_end) begin
         if (w_full || in_kind == c_k_rsvd) begin
            w_err_set = 1'b1;
         end else begin
            w_write = 1'b1;
         end
      end
`ifdef ENC_BRANCH_DELAY_NOP_EN
      if (r_state == c_pad && !start) begin
         if (w_full) begin
            w_err_set = 1'b1;
         end else begin
            w_write   = 1'b1;
            w_wr_word = 32'h0000_0000;
         end
      end
`endif
   end

   // Write port, pointer, counter and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ptr   <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_we <= w_write;
         if (w_write) begin
            r_addr  <= r_ptr;
            r_wdata <= w_wr_word;
         end
         if (start) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
         end else begin
            if (w_write) begin
               r_count <= r_count + c_cnt_one;
               if (r_ptr != c_ptr_last) r_ptr <= r_ptr + c_ptr_one;
            end
            if (w_err_set) r_err <= 1'b1;
         end
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign err        = r_err;
   assign count      = r_count;

endmodule
`default_nettype wire
